// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write arbiter: FSM state encoding and grant-index width.
// Pure declarations; no logic, no latency.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_ARB        = 2'd0,
    ST_CLR_ASSERT = 2'd1,
    ST_CLR_WAIT   = 2'd2
  } fb_state_e;

  function automatic int grant_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit scanning upward from ptr, wrapping.
// Zero latency; found_o low when no request is set.
module rr_pick
  import fb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               found_o
);

  int idx;

  // Scan from the farthest offset down so the closest set bit to ptr is the last one written.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid_i[idx]) begin
        winner_o = IDX_W'(idx);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin arbiter with bounded bursts sharing the framebuffer write port, plus frame-clear sequencing.
// One registered stage to the fb port; requesters see ready only in ARB with no clear request or fb clear busy.
module framebuffer_write_arbiter
  import fb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int ADDR_WIDTH     = 19,
  parameter  int DATA_WIDTH     = 8,
  parameter  int BURST_MAX      = 16,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int GRANT_W        = grant_w(NUM_REQ)
) (
  input  logic                          clk_wr_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          clr_req_i,
  output logic                          clr_done_o,
  output logic                          busy_o,
  output logic                          fb_rst_req_n_o,
  input  logic                          fb_rst_busy_i,
  output logic                          fb_en_wr_o,
  output logic                          fb_wrea_o,
  output logic [ADDR_WIDTH-1:0]         fb_addr_wr_o,
  output logic [DATA_WIDTH-1:0]         fb_din_o,
  output logic [GRANT_W-1:0]            grant_id_o
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  fb_state_e              state_q;
  logic [GRANT_W-1:0]     ptr_q, ptr_d, win;
  logic [CNT_W-1:0]       cnt_q, cnt_d, burst_n;
  logic                   found, xfer;
  logic                   wr_en_q, clr_done_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  din_q;
  logic [GRANT_W-1:0]     gid_q;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i  (req_valid_i),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .found_o  (found)
  );

  // A pending clear request or an active fb clear blocks every grant in that cycle.
  assign xfer = (state_q == ST_ARB) && !clr_req_i && !fb_rst_busy_i && found;

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[win] = 1'b1;
  end

  // Burst count continues only while the same requester keeps winning from the pointer.
  always_comb begin
    burst_n = ((win == ptr_q) ? cnt_q : '0) + CNT_W'(1);
    ptr_d   = win;
    cnt_d   = burst_n;
    if (burst_n == CNT_W'(BURST_MAX)) begin
      ptr_d = (win == GRANT_W'(NUM_REQ - 1)) ? '0 : win + GRANT_W'(1);
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_wr_i) begin
    if (!rst_n_i) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLR_ASSERT : ST_ARB;
      ptr_q      <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      gid_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      wr_en_q    <= xfer;
      case (state_q)
        ST_ARB:        if (clr_req_i) state_q <= ST_CLR_ASSERT;
        ST_CLR_ASSERT: state_q <= ST_CLR_WAIT;
        ST_CLR_WAIT: begin
          if (!fb_rst_busy_i) begin
            state_q    <= ST_ARB;
            clr_done_q <= 1'b1;
          end
        end
        default:       state_q <= ST_ARB;
      endcase
      if (xfer) begin
        ptr_q  <= ptr_d;
        cnt_q  <= cnt_d;
        addr_q <= req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
        din_q  <= req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
        gid_q  <= win;
      end
    end
  end

  assign fb_rst_req_n_o = (state_q != ST_CLR_ASSERT);
  assign busy_o         = (state_q != ST_ARB);
  assign clr_done_o     = clr_done_q;
  assign fb_en_wr_o     = wr_en_q;
  assign fb_wrea_o      = wr_en_q;
  assign fb_addr_wr_o   = addr_q;
  assign fb_din_o       = din_q;
  assign grant_id_o     = gid_q;

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Bench for framebuffer_write_arbiter: burst/round-robin grants, fb port pipeline, clear sequencing, reset.
// DUT a: BURST_MAX=16 with clear on reset; DUT b: BURST_MAX=1 without.
module tb_framebuffer_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [75:0] req_addr;
  logic [31:0] req_data;
  logic        clr_req;
  logic        fb_rst_busy;
  logic        sel;

  logic [3:0]  a_rdy, b_rdy;
  logic        a_done, b_done, a_busy, b_busy, a_rstn, b_rstn;
  logic        a_en, b_en, a_wrea, b_wrea;
  logic [18:0] a_addr, b_addr;
  logic [7:0]  a_din, b_din;
  logic [1:0]  a_gid, b_gid;

  logic [3:0]  rdy;
  logic        done, busy, rstn, en, wrea;
  logic [18:0] addr;
  logic [7:0]  din;
  logic [1:0]  gid;

  logic [18:0] tab_addr [4];
  logic [7:0]  tab_data [4];

  typedef struct {
    int          id;
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  framebuffer_write_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(19), .DATA_WIDTH(8), .BURST_MAX(16), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk_wr_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(a_rdy), .clr_req_i(clr_req), .clr_done_o(a_done),
    .busy_o(a_busy), .fb_rst_req_n_o(a_rstn), .fb_rst_busy_i(fb_rst_busy), .fb_en_wr_o(a_en),
    .fb_wrea_o(a_wrea), .fb_addr_wr_o(a_addr), .fb_din_o(a_din), .grant_id_o(a_gid)
  );

  framebuffer_write_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(19), .DATA_WIDTH(8), .BURST_MAX(1), .CLEAR_ON_RESET(0)
  ) u_dut_b (
    .clk_wr_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(b_rdy), .clr_req_i(clr_req), .clr_done_o(b_done),
    .busy_o(b_busy), .fb_rst_req_n_o(b_rstn), .fb_rst_busy_i(fb_rst_busy), .fb_en_wr_o(b_en),
    .fb_wrea_o(b_wrea), .fb_addr_wr_o(b_addr), .fb_din_o(b_din), .grant_id_o(b_gid)
  );

  assign rdy  = sel ? b_rdy  : a_rdy;
  assign done = sel ? b_done : a_done;
  assign busy = sel ? b_busy : a_busy;
  assign rstn = sel ? b_rstn : a_rstn;
  assign en   = sel ? b_en   : a_en;
  assign wrea = sel ? b_wrea : a_wrea;
  assign addr = sel ? b_addr : a_addr;
  assign din  = sel ? b_din  : a_din;
  assign gid  = sel ? b_gid  : a_gid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_tabs(input int k);
    for (int i = 0; i < 4; i++) begin
      tab_addr[i] = 19'(i * 4096 + k);
      tab_data[i] = 8'(i * 50 + k);
    end
  endtask

  // One cycle: drive at negedge, check the fb port against the previous grant, then this cycle's ready.
  task automatic step(input logic [3:0] vld, input logic clr, input logic fbb, input int win,
                      input logic e_rstn, input logic e_busy, input logic e_done);
    exp_t e;
    @(negedge clk);
    req_valid   = vld;
    clr_req     = clr;
    fb_rst_busy = fbb;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*19 +: 19] = tab_addr[i];
      req_data[i*8 +: 8]   = tab_data[i];
    end
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("fb_en_wr", 32'(en), 32'd1);
      check("fb_wrea", 32'(wrea), 32'd1);
      check("grant_id", 32'(gid), 32'(e.id));
      check("fb_addr_wr", 32'(addr), 32'(e.addr));
      check("fb_din", 32'(din), 32'(e.data));
    end else begin
      check("fb_idle", 32'(en), 32'd0);
    end
    check("req_ready", 32'(rdy), (win < 0) ? 32'd0 : (32'd1 << win));
    check("fb_rst_req_n", 32'(rstn), 32'(e_rstn));
    check("busy", 32'(busy), 32'(e_busy));
    check("clr_done", 32'(done), 32'(e_done));
    if (win >= 0) begin
      e.id   = win;
      e.addr = tab_addr[win];
      e.data = tab_data[win];
      sb.push_back(e);
    end
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; req_valid = '0; clr_req = 1'b0; fb_rst_busy = 1'b0;
    req_addr = '0; req_data = '0;
    fill_tabs(0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_a_en", 32'(a_en), 32'd0);
    check("rst_a_addr", 32'(a_addr), 32'd0);
    check("rst_a_din", 32'(a_din), 32'd0);
    check("rst_a_gid", 32'(a_gid), 32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_a_rstreq", 32'(a_rstn), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd1);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    check("rst_b_rstreq", 32'(b_rstn), 32'd1);
    check("rst_b_en", 32'(b_en), 32'd0);

    // Pure round robin between requesters 1 and 3 on DUT b.
    rst_n = 1'b1;
    sel   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fill_tabs(100 + k);
      step(4'b1010, 1'b0, 1'b0, (k % 2 == 0) ? 1 : 3, 1'b1, 1'b0, 1'b0);
    end
    step(4'b0000, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);

    // DUT a: clear sequence straight out of reset.
    rst_n = 1'b0;
    sel   = 1'b0;
    step(4'b0000, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (3) step(4'b1111, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0);

    // Bursts of 16 per requester, wrapping back to 0.
    for (int k = 0; k < 68; k++) begin
      fill_tabs(k);
      step(4'b1111, 1'b0, 1'b0, (k / 16) % 4, 1'b1, 1'b0, (k == 0));
    end

    // Clear request wins over all valids; one-cycle assert, wait on fb busy.
    step(4'b1111, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    repeat (3) step(4'b1111, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0);
    tab_addr[0] = 19'h00100;
    tab_data[0] = 8'hA5;
    step(4'b0001, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);

    // Reset during CLR_WAIT, with a stray clear request that must be ignored.
    step(4'b0000, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1, -1, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(4'b0000, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(4'b0000, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, -1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
